// File: rtl/twos_serial_tx_if.sv
// Handshake and serial-output bundle for twos_serial_tx.
// The master drives din/din_valid; the slave (the serializer) drives everything else.
interface twos_serial_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             i;
    logic             r;
    logic             sv;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, i, r, sv, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, i, r, sv, busy
    );
endinterface

// File: rtl/twos_serial_tx.sv
// LSB-first parallel-to-serial source feeding the bit-serial two's-complement unit.
// Define TWOS_TX_SKID_EN to add a one-word hold register for gapless back-to-back frames.
module twos_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic            i_t_clk,
    input  logic            i_rn,
    twos_serial_tx_if.slave s_bus
);
    // state    | meaning
    // ST_IDLE  | no frame; r=1 keeps the downstream unit cleared
    // ST_SHIFT | emitting shifter[0], cnt = bit index within frame
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic             w_xfer;
    logic             w_last;
    logic             w_ready;

`ifdef TWOS_TX_SKID_EN
    logic [WIDTH-1:0] r_hold, w_hold_nxt;
    logic             r_hold_full, w_hold_full_nxt;

    assign w_ready = i_rn & ~r_hold_full;
`else
    assign w_ready = i_rn & (r_state == ST_IDLE);
`endif

    assign w_xfer = s_bus.din_valid & w_ready;
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_t_clk) begin
        if (!i_rn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
`ifdef TWOS_TX_SKID_EN
            r_hold      <= '0;
            r_hold_full <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
`ifdef TWOS_TX_SKID_EN
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
`ifdef TWOS_TX_SKID_EN
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
`endif
        case (r_state)
            ST_IDLE: begin
                // The hold register is always empty here: it drains at every frame end.
                if (w_xfer) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = s_bus.din;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_cnt + CW'(1);
`ifdef TWOS_TX_SKID_EN
                    if (w_xfer) begin
                        w_hold_nxt      = s_bus.din;
                        w_hold_full_nxt = 1'b1;
                    end
`endif
                end else begin
`ifdef TWOS_TX_SKID_EN
                    if (r_hold_full) begin
                        // Oldest word first; a word arriving now refills the slot just freed.
                        w_shift_nxt     = r_hold;
                        w_cnt_nxt       = '0;
                        w_hold_full_nxt = w_xfer;
                        if (w_xfer) begin
                            w_hold_nxt = s_bus.din;
                        end
                    end else if (w_xfer) begin
                        w_shift_nxt = s_bus.din;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_bus.din_ready = w_ready;
    assign s_bus.i         = (r_state == ST_SHIFT) & r_shift[0];
    assign s_bus.r         = (r_state == ST_IDLE) | (r_cnt == '0);
    assign s_bus.sv        = (r_state == ST_SHIFT);
    assign s_bus.busy      = (r_state == ST_SHIFT);
endmodule
